pipeline_credit_gate: RTL
=========================

Name: pipeline_credit_gate

Overview:
- Issuing-side counterpart to the pipeline occupancy tracker: it admits values into a fixed-latency float pipeline that has no backpressure, and limits how many are outstanding.
- Outstanding = values inside the pipeline plus values buffered in the downstream result FIFO. Credits are returned when the consumer pops the FIFO.
- Provides a four-phase drain handshake so control logic can stop intake and wait until the pipeline and FIFO are empty, e.g. before reconfiguration.

Parameters:
- CREDITS, 16, maximum outstanding values; equals the result FIFO depth. Legal range 1..(2^CNT_W - 1).
- CNT_W, 5, width of the outstanding counter.

Ports:
- aclk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- s_valid  in  1  upstream has a value to issue.
- s_ready  out  1  gate accepts a value this cycle.
- pipe_valid  out  1  issue strobe to the pipeline input; equals s_valid & s_ready.
- out_consume  in  1  downstream popped one result from the FIFO (returns one credit).
- outstanding  out  CNT_W  registered count of outstanding values.
- drain_req  in  1  request to stop intake and empty the pipeline.
- drain_ack  out  1  registered; pipeline and FIFO are empty and intake is stopped.
- idle  out  1  registered; outstanding == 0.
- underflow_err  out  1  sticky; set when a consume arrives with nothing outstanding.

Behaviour:
- Reset (asynchronous, resetn = 0): outstanding = 0, state = RUN, drain_ack = 0, idle = 1, underflow_err = 0. Reset is honoured at any point, including mid-drain. Values already inside the pipeline when reset is applied are forgotten.
- s_ready = (state == RUN) && (outstanding < CREDITS). It depends only on registers, never combinationally on s_valid or out_consume.
- pipe_valid = s_valid && s_ready. One issue per cycle at most.
- Counter update per clock, where issue = pipe_valid and cons = out_consume:
  - issue & !cons: +1.
  - !issue & cons & outstanding != 0: -1.
  - issue & cons: unchanged, including at outstanding == CREDITS and outstanding == 0.
  - !issue & cons & outstanding == 0: unchanged, and underflow_err is set to 1.
- The counter never wraps. A credit returned in cycle N becomes visible in s_ready at cycle N+1 (latency of 1).
- underflow_err is cleared only by reset.
- idle is registered from the next counter value, so it follows outstanding with no extra delay.
- FSM states RUN, DRAIN, DONE:
  - RUN: if drain_req = 1 → DRAIN. s_ready is 0 from the next cycle; an issue in the same cycle drain_req rises is still accepted.
  - DRAIN: s_ready = 0. When outstanding == 0, counting this cycle's update, → DONE and drain_ack goes to 1 on that edge.
  - DONE: s_ready = 0, drain_ack = 1. If drain_req = 0 → RUN and drain_ack goes to 0 on that edge.
  - If drain_req drops while in DRAIN: stay in DRAIN until empty, then enter DONE and drop immediately to RUN on the next edge. drain_ack pulses for one cycle.
  - drain_req rising while outstanding is already 0: RUN → DRAIN → DONE. drain_ack is high 2 cycles after drain_req rises.
- out_consume is accepted in every state.

Test Plan:
- Reset then hold s_valid = 1 with no consumes, CREDITS = 16 → exactly 16 pipe_valid pulses, then s_ready = 0 and outstanding = 16, idle = 0.
- At outstanding = 16, assert out_consume for 1 cycle → outstanding = 15 next cycle, s_ready = 1 one cycle later than the consume, one more issue occurs, outstanding returns to 16.
- Simultaneous issue and consume for 20 cycles at outstanding = 5 → outstanding stays 5, 20 pipe_valid pulses, no underflow_err.
- With outstanding = 3, raise drain_req and hold; 3 consumes on separated cycles → s_ready = 0 throughout, drain_ack rises on the edge after the 3rd consume. Drop drain_req → drain_ack falls next edge and s_ready returns.
- Consume with outstanding = 0 → outstanding stays 0, underflow_err = 1 and stays 1 until resetn pulses low.
- Assert resetn = 0 asynchronously mid-DRAIN with outstanding = 7 → outputs take reset values immediately without a clock edge, and state is RUN after release.

Source files
------------

// File: rtl/pipeline_credit_gate.sv
// -----------------------------------------------------------------------------
// pipeline_credit_gate
//
// Issue gate for a fixed-latency pipeline that cannot stall. The pipeline
// feeds a result FIFO of CREDITS entries. The gate counts values that are
// either in flight or buffered in that FIFO. It refuses new values once that
// count reaches CREDITS, so the FIFO can never overflow. A credit is returned
// each time the consumer pops the FIFO.
//
// A four-phase drain handshake (drain_req / drain_ack) stops intake and reports
// when everything issued has been consumed.
//
// Ports
//   aclk          in   clock, rising edge
//   resetn        in   asynchronous active-low reset
//   s_valid       in   upstream offers a value
//   s_ready       out  gate accepts a value this cycle (registers only)
//   pipe_valid    out  issue strobe into the pipeline (s_valid & s_ready)
//   out_consume   in   consumer popped one result (returns one credit)
//   outstanding   out  registered count of values in pipeline + FIFO
//   drain_req     in   request to stop intake and empty the pipeline
//   drain_ack     out  registered, pipeline/FIFO empty with intake stopped
//   idle          out  registered, outstanding == 0
//   underflow_err out  sticky, consume seen with nothing outstanding
// -----------------------------------------------------------------------------
module pipeline_credit_gate #(
    parameter int CREDITS = 16,
    parameter int CNT_W   = 5
) (
    input  logic             aclk,
    input  logic             resetn,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             pipe_valid,
    input  logic             out_consume,
    output logic [CNT_W-1:0] outstanding,
    input  logic             drain_req,
    output logic             drain_ack,
    output logic             idle,
    output logic             underflow_err
);

    localparam logic [CNT_W-1:0] CREDITS_C = CNT_W'(CREDITS);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic             idle_q, idle_d;
    logic             uf_q, uf_d;
    logic             issue;

    // s_ready uses only registered state. The upstream handshake therefore
    // never forms a combinational loop through s_valid or out_consume.
    assign s_ready    = (state_q == RUN) && (cnt_q < CREDITS_C);
    assign issue      = s_valid && s_ready;
    assign pipe_valid = issue;

    always_comb begin
        cnt_d = cnt_q;
        uf_d  = uf_q;
        if (issue && !out_consume) begin
            cnt_d = cnt_q + ONE_C;
        end else if (!issue && out_consume) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - ONE_C;
            end else begin
                uf_d = 1'b1;
            end
        end
        // An issue paired with a consume leaves the count unchanged.
        idle_d = (cnt_d == '0);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (drain_req) state_d = DRAIN;
            // Check the post-update count. The last consume then moves to DONE
            // on the same edge.
            DRAIN:   if (cnt_d == '0) state_d = DONE;
            DONE:    if (!drain_req) state_d = RUN;
            default: state_d = RUN;
        endcase
        ack_d = (state_d == DONE);
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state_q <= RUN;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            idle_q  <= 1'b1;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            idle_q  <= idle_d;
            uf_q    <= uf_d;
        end
    end

    assign outstanding   = cnt_q;
    assign drain_ack     = ack_q;
    assign idle          = idle_q;
    assign underflow_err = uf_q;

endmodule
